// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: controller
// state encoding and the default geometry.
package icache_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MISS = 1'b1
   } icache_state_t;

   localparam int ICACHE_LINES     = 256;
   localparam int ICACHE_ADDR_BITS = 18;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache, one 32-bit word per line.
// Define ICACHE_PERF_EN to add the hit_cnt/miss_cnt performance counters.
module icache
   import icache_pkg::*;
#(
   parameter int LINES = ICACHE_LINES
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rdy,
   input  logic          jump_rst,
   input  logic          fetch_valid,
   input  logic [31:0]   fetch_addr,
   output logic          fetch_ready,
   output logic [31:0]   fetch_inst,
   output logic          IF_valid,
   output logic [31:0]   IF_addr,
   input  logic          IF_send,
   input  logic [31:0]   IF_inst,
`ifdef ICACHE_PERF_EN
   output logic [31:0]   hit_cnt,
   output logic [31:0]   miss_cnt,
`endif
   output icache_state_t dbg_state
);

   localparam int IDX   = $clog2(LINES);
   localparam int TAG_W = ICACHE_ADDR_BITS - IDX - 2;

   // Handshakes: fetch_valid is held by the consumer until the one-cycle
   // fetch_ready pulse; IF_valid is held with a stable IF_addr until IF_send
   // is sampled, and drops on that same edge so no second fetch starts.

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   icache_state_t state_q, state_d;

   logic [IDX-1:0]   rd_idx, fill_idx;
   logic [TAG_W-1:0] rd_tag, fill_tag;
   logic             hit;
   logic             ready_d, ifv_d, fill;
   logic [31:0]      inst_d, ifa_d;
   logic             lookup_hit, lookup_miss;
   logic             unused_addr_bits;

   assign rd_idx   = fetch_addr[IDX+1:2];
   assign rd_tag   = fetch_addr[ICACHE_ADDR_BITS-1:IDX+2];
   assign fill_idx = IF_addr[IDX+1:2];
   assign fill_tag = IF_addr[ICACHE_ADDR_BITS-1:IDX+2];
   assign hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign unused_addr_bits = ^{fetch_addr[31:ICACHE_ADDR_BITS], fetch_addr[1:0],
                               IF_addr[31:ICACHE_ADDR_BITS], IF_addr[1:0]};
   assign dbg_state = state_q;

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else if (rdy)
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (jump_rst) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (fetch_valid && !hit) state_d = ST_MISS;
            ST_MISS: if (IF_send) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Next values of the registered outputs and the fill strobe.
   always_comb begin
      ready_d     = 1'b0;
      inst_d      = fetch_inst;
      ifv_d       = IF_valid;
      ifa_d       = IF_addr;
      fill        = 1'b0;
      lookup_hit  = 1'b0;
      lookup_miss = 1'b0;
      if (jump_rst) begin
         ifv_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fetch_valid) begin
                  if (hit) begin
                     ready_d    = 1'b1;
                     inst_d     = data_q[rd_idx];
                     lookup_hit = 1'b1;
                  end else begin
                     ifv_d       = 1'b1;
                     ifa_d       = fetch_addr;
                     lookup_miss = 1'b1;
                  end
               end
            end
            ST_MISS: begin
               if (IF_send) begin
                  fill    = 1'b1;
                  ready_d = 1'b1;
                  inst_d  = IF_inst;
                  ifv_d   = 1'b0;
               end
            end
            default: ifv_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= '0;
         fetch_ready <= 1'b0;
         fetch_inst  <= '0;
         IF_valid    <= 1'b0;
         IF_addr     <= '0;
      end else if (rdy) begin
         fetch_ready <= ready_d;
         fetch_inst  <= inst_d;
         IF_valid    <= ifv_d;
         IF_addr     <= ifa_d;
         if (fill)
            valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag and data storage carry no reset; the valid bits gate them.
   always_ff @(posedge clk) begin
      if (!rst && rdy && fill) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= IF_inst;
      end
   end

`ifdef ICACHE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (rdy) begin
         if (lookup_hit)
            hit_cnt <= hit_cnt + 32'd1;
         if (lookup_miss)
            miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// scored against a word-address cache model and a lazily filled memory.
module tb_icache;
   import icache_pkg::*;

   localparam int LINES = 256;

   logic          clk = 1'b0;
   logic          rst, rdy, jump_rst, fetch_valid, IF_send;
   logic [31:0]   fetch_addr, IF_inst;
   logic          fetch_ready, IF_valid;
   logic [31:0]   fetch_inst, IF_addr;
   icache_state_t dbg_state;
`ifdef ICACHE_PERF_EN
   logic [31:0]   hit_cnt, miss_cnt;
`endif

   int vectors = 0;
   int errors  = 0;

   // Reference model: which word address each line holds, and backing memory.
   logic        model_v  [LINES];
   int          model_wa [LINES];
   logic [31:0] mem [int];
   logic [31:0] exp_q [$];
   logic [31:0] last_inst;

   icache #(.LINES(LINES)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .jump_rst    (jump_rst),
      .fetch_valid (fetch_valid),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .fetch_inst  (fetch_inst),
      .IF_valid    (IF_valid),
      .IF_addr     (IF_addr),
      .IF_send     (IF_send),
      .IF_inst     (IF_inst),
`ifdef ICACHE_PERF_EN
      .hit_cnt     (hit_cnt),
      .miss_cnt    (miss_cnt),
`endif
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      int k;
      k = int'(addr[17:2]);
      if (!mem.exists(k))
         mem[k] = $urandom;
      return mem[k];
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < LINES; i++) model_v[i] = 1'b0;
      last_inst = '0;
   endfunction

   // Full fetch transaction; lat = idle cycles before IF_send on a miss.
   task automatic fetch(input logic [31:0] addr, input int lat);
      int          idx;
      logic        exp_hit;
      logic [31:0] w, e;
      idx     = int'(addr[17:2]) % LINES;
      exp_hit = model_v[idx] && (model_wa[idx] == int'(addr[17:2]));
      w       = mem_word(addr);
      exp_q.push_back(w);
      @(negedge clk);
      fetch_valid = 1'b1;
      fetch_addr  = addr;
      @(negedge clk);
      vectors++;
      if (exp_hit) begin
         if (fetch_ready !== 1'b1 || IF_valid !== 1'b0) begin
            errors++;
            $display("FAIL hit_resp addr=%h: ready=%b if_valid=%b, want ready=1 if_valid=0",
                     addr, fetch_ready, IF_valid);
         end
      end else begin
         if (fetch_ready !== 1'b0 || IF_valid !== 1'b1 || IF_addr !== addr) begin
            errors++;
            $display("FAIL miss_req addr=%h: ready=%b if_valid=%b if_addr=%h, want 0 1 %h",
                     addr, fetch_ready, IF_valid, IF_addr, addr);
         end
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            vectors++;
            if (fetch_ready !== 1'b0 || IF_valid !== 1'b1 || IF_addr !== addr) begin
               errors++;
               $display("FAIL miss_wait addr=%h: ready=%b if_valid=%b if_addr=%h, want 0 1 %h",
                        addr, fetch_ready, IF_valid, IF_addr, addr);
            end
         end
         IF_send = 1'b1;
         IF_inst = w;
         @(negedge clk);
         IF_send = 1'b0;
         IF_inst = $urandom;
         vectors++;
         if (fetch_ready !== 1'b1 || IF_valid !== 1'b0) begin
            errors++;
            $display("FAIL miss_fill addr=%h: ready=%b if_valid=%b, want ready=1 if_valid=0",
                     addr, fetch_ready, IF_valid);
         end
         model_v[idx]  = 1'b1;
         model_wa[idx] = int'(addr[17:2]);
      end
      e = exp_q.pop_front();
      vectors++;
      if (fetch_inst !== e) begin
         errors++;
         $display("FAIL fetch_inst addr=%h: got %h want %h", addr, fetch_inst, e);
      end
      last_inst   = e;
      fetch_valid = 1'b0;
      fetch_addr  = $urandom;
      @(negedge clk);
      vectors++;
      if (fetch_ready !== 1'b0 || fetch_inst !== last_inst) begin
         errors++;
         $display("FAIL pulse_end addr=%h: ready=%b inst=%h, want 0 %h",
                  addr, fetch_ready, fetch_inst, last_inst);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b0; jump_rst = 1'b1;
      fetch_valid = 1'b1; fetch_addr = 32'h0; IF_send = 1'b0; IF_inst = '0;
      repeat (2) @(negedge clk);
      vectors++;
      if (fetch_ready !== 1'b0 || fetch_inst !== 32'h0 || IF_valid !== 1'b0 ||
          IF_addr !== 32'h0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset: ready=%b inst=%h if_valid=%b if_addr=%h state=%0d, want all 0",
                  fetch_ready, fetch_inst, IF_valid, IF_addr, dbg_state);
      end
      rst = 1'b0; rdy = 1'b1; jump_rst = 1'b0; fetch_valid = 1'b0;
      model_clear();
      @(negedge clk);
   endtask

   task automatic test_cold_miss_and_hit();
      mem[0] = 32'h0000_0013;
      fetch(32'h0000_0000, 2);
      fetch(32'h0000_0000, 0);
   endtask

   task automatic test_conflict();
      fetch(32'h0000_0400, 1);
      fetch(32'h0000_0000, 3);
   endtask

   task automatic test_jump();
      @(negedge clk);
      fetch_valid = 1'b1; fetch_addr = 32'h0000_0008;
      repeat (2) @(negedge clk);
      jump_rst = 1'b1;
      @(negedge clk);
      jump_rst = 1'b0; fetch_valid = 1'b0;
      vectors++;
      if (IF_valid !== 1'b0 || fetch_ready !== 1'b0 || dbg_state !== ST_IDLE ||
          fetch_inst !== last_inst) begin
         errors++;
         $display("FAIL jump_abort: if_valid=%b ready=%b state=%0d inst=%h, want 0 0 0 %h",
                  IF_valid, fetch_ready, dbg_state, fetch_inst, last_inst);
      end
      // Flush coinciding with the memory response: no fill, no pulse.
      fetch_valid = 1'b1; fetch_addr = 32'h0000_000c;
      @(negedge clk);
      IF_send = 1'b1; IF_inst = mem_word(32'h0000_000c); jump_rst = 1'b1;
      @(negedge clk);
      IF_send = 1'b0; jump_rst = 1'b0; fetch_valid = 1'b0;
      vectors++;
      if (IF_valid !== 1'b0 || fetch_ready !== 1'b0 || fetch_inst !== last_inst) begin
         errors++;
         $display("FAIL jump_vs_send: if_valid=%b ready=%b inst=%h, want 0 0 %h",
                  IF_valid, fetch_ready, fetch_inst, last_inst);
      end
      @(negedge clk);
      fetch(32'h0000_0000, 0);
      fetch(32'h0000_0008, 2);
      fetch(32'h0000_000c, 1);
   endtask

   task automatic test_rdy_freeze();
      logic [31:0] held;
      held = last_inst;
      @(negedge clk);
      fetch_valid = 1'b1; fetch_addr = 32'h0000_0000; rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (fetch_ready !== 1'b0 || fetch_inst !== held || IF_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdy_hold cyc=%0d: ready=%b inst=%h if_valid=%b, want 0 %h 0",
                     i, fetch_ready, fetch_inst, IF_valid, held);
         end
      end
      rdy = 1'b1;
      @(negedge clk);
      fetch_valid = 1'b0;
      vectors++;
      if (fetch_ready !== 1'b1 || fetch_inst !== mem_word(32'h0)) begin
         errors++;
         $display("FAIL rdy_resume: ready=%b inst=%h, want 1 %h",
                  fetch_ready, fetch_inst, mem_word(32'h0));
      end
      last_inst = mem_word(32'h0);
      @(negedge clk);
      vectors++;
      if (fetch_ready !== 1'b0) begin
         errors++;
         $display("FAIL rdy_single_pulse: ready=%b want 0", fetch_ready);
      end
   endtask

   task automatic test_reset_mid_miss();
      @(negedge clk);
      fetch_valid = 1'b1; fetch_addr = 32'h0000_0014;
      @(negedge clk);
      IF_send = 1'b1; IF_inst = mem_word(32'h0000_0014); rst = 1'b1;
      @(negedge clk);
      IF_send = 1'b0; rst = 1'b0; fetch_valid = 1'b0;
      vectors++;
      if (IF_valid !== 1'b0 || fetch_ready !== 1'b0 || fetch_inst !== 32'h0 ||
          dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_mid_miss: if_valid=%b ready=%b inst=%h state=%0d, want 0 0 0 0",
                  IF_valid, fetch_ready, fetch_inst, dbg_state);
      end
      model_clear();
      fetch(32'h0000_0014, 1);
      fetch(32'h0000_0000, 0);
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 120; n++) begin
         a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2);
         fetch(a, $urandom_range(0, 3));
      end
   endtask

`ifdef ICACHE_PERF_EN
   task automatic test_perf();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      fetch(32'h0000_0020, 1);
      fetch(32'h0000_0020, 0);
      fetch(32'h0000_0020, 0);
      fetch(32'h0000_0420, 2);
      vectors++;
      if (hit_cnt !== 32'd2 || miss_cnt !== 32'd2) begin
         errors++;
         $display("FAIL perf_counts: hit=%0d miss=%0d, want 2 2", hit_cnt, miss_cnt);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      vectors++;
      if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
         errors++;
         $display("FAIL perf_reset: hit=%0d miss=%0d, want 0 0", hit_cnt, miss_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_cold_miss_and_hit();
      test_conflict();
      test_jump();
      test_rdy_freeze();
      test_reset_mid_miss();
      test_random();
`ifdef ICACHE_PERF_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
